snapreg_seq: RTL and testbench

Batch sequencer for the DRCP snapshot register file. It accepts one save or restore command covering an arbitrary register range and splits it into chunks of at most BATCH_MAX registers. For each chunk it moves data between the core GPR batch ports and the snapshot regfile's sreg request interface. It sits between the DRCP custom-instruction decoder and the snapshot regfile, and it is the only master of the sreg interface.

---
 rtl/snapreg_seq.sv | 179 +++++++++++++++++
 tb/tb_snapreg_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snapreg_seq.sv
// Batch sequencer for the DRCP snapshot register file: splits one save/restore command
// into chunks of at most BATCH_MAX registers and moves them between GPR and sreg ports.
module snapreg_seq #(
  parameter int unsigned BATCH_MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_restore_i,
  input  logic [4:0]              cmd_start_i,
  input  logic [5:0]              cmd_len_i,
  output logic                    done_o,
  output logic                    error_o,
  output logic                    sreg_req_o,
  output logic [6:0]              sreg_funct7_o,
  output logic [4:0]              sreg_batch_start_o,
  output logic [4:0]              sreg_batch_len_o,
  output logic [32*BATCH_MAX-1:0] sreg_rs_val_o,
  input  logic                    sreg_ack_i,
  input  logic                    sreg_error_i,
  input  logic [32*BATCH_MAX-1:0] sreg_rd_val_i,
  output logic                    gpr_rd_req_o,
  output logic [4:0]              gpr_rd_base_o,
  input  logic [32*BATCH_MAX-1:0] gpr_rd_data_i,
  output logic                    gpr_wr_o,
  output logic [4:0]              gpr_wr_base_o,
  output logic [4:0]              gpr_wr_len_o,
  output logic [32*BATCH_MAX-1:0] gpr_wr_data_o
);

  localparam int unsigned DataW     = 32 * BATCH_MAX;
  localparam logic [5:0]  BatchMaxW = 6'(BATCH_MAX);
  localparam logic [6:0]  Funct7Wr  = 7'b0000000;
  localparam logic [6:0]  Funct7Rd  = 7'b1000000;

  typedef enum logic [2:0] {
    StIdle,
    StSRd,
    StSCap,
    StSWr,
    StRRd,
    StRWr,
    StDone
  } state_e;

  state_e           state_q;
  logic [5:0]       cur_q;
  logic [5:0]       rem_q;
  logic             err_q;
  logic [DataW-1:0] buf_q;

  logic [5:0]       chunk;
  logic [6:0]       cmd_end;
  logic             cmd_illegal;
  logic [DataW-1:0] lane_data;

  assign chunk       = (rem_q > BatchMaxW) ? BatchMaxW : rem_q;
  assign cmd_end     = {2'b00, cmd_start_i} + {1'b0, cmd_len_i};
  assign cmd_illegal = (cmd_len_i == 6'd0) || (cmd_end > 7'd32);

  // Lanes past the current chunk are forced to zero so stale buffer data never leaks.
  always_comb begin
    lane_data = '0;
    for (int unsigned i = 0; i < BATCH_MAX; i++) begin
      if (6'(i) < chunk) begin
        lane_data[i*32 +: 32] = buf_q[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cur_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            cur_q <= {1'b0, cmd_start_i};
            rem_q <= cmd_len_i;
            if (cmd_illegal) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= cmd_restore_i ? StRRd : StSRd;
            end
          end
        end
        StSRd: state_q <= StSCap;
        StSCap: begin
          buf_q   <= gpr_rd_data_i;
          state_q <= StSWr;
        end
        StSWr: begin
          if (sreg_ack_i) begin
            if (sreg_error_i) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              cur_q   <= cur_q + chunk;
              rem_q   <= rem_q - chunk;
              state_q <= (rem_q == chunk) ? StDone : StSRd;
            end
          end
        end
        StRRd: begin
          if (sreg_ack_i) begin
            if (sreg_error_i) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              buf_q   <= sreg_rd_val_i;
              state_q <= StRWr;
            end
          end
        end
        StRWr: begin
          cur_q   <= cur_q + chunk;
          rem_q   <= rem_q - chunk;
          state_q <= (rem_q == chunk) ? StDone : StRRd;
        end
        StDone: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only; request fields are zero outside their states.
  always_comb begin
    cmd_ready_o        = (state_q == StIdle);
    done_o             = (state_q == StDone);
    error_o            = (state_q == StDone) && err_q;
    sreg_req_o         = 1'b0;
    sreg_funct7_o      = '0;
    sreg_batch_start_o = '0;
    sreg_batch_len_o   = '0;
    sreg_rs_val_o      = '0;
    gpr_rd_req_o       = 1'b0;
    gpr_rd_base_o      = '0;
    gpr_wr_o           = 1'b0;
    gpr_wr_base_o      = '0;
    gpr_wr_len_o       = '0;
    gpr_wr_data_o      = '0;
    unique case (state_q)
      StSRd: begin
        gpr_rd_req_o  = 1'b1;
        gpr_rd_base_o = cur_q[4:0];
      end
      StSWr: begin
        sreg_req_o         = 1'b1;
        sreg_funct7_o      = Funct7Wr;
        sreg_batch_start_o = cur_q[4:0];
        sreg_batch_len_o   = chunk[4:0];
        sreg_rs_val_o      = lane_data;
      end
      StRRd: begin
        sreg_req_o         = 1'b1;
        sreg_funct7_o      = Funct7Rd;
        sreg_batch_start_o = cur_q[4:0];
        sreg_batch_len_o   = chunk[4:0];
      end
      StRWr: begin
        gpr_wr_o      = 1'b1;
        gpr_wr_base_o = cur_q[4:0];
        gpr_wr_len_o  = chunk[4:0];
        gpr_wr_data_o = lane_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snapreg_seq.sv
// Self-checking bench for snapreg_seq: vector table of commands, sreg/GPR responders and a
// scoreboard of expected sreg requests and GPR writes.
module tb_snapreg_seq;

  localparam int BM = 4;
  localparam int DW = 32 * BM;
  localparam int OW = 38 + 2 * DW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cmd_valid_i, cmd_ready_o, cmd_restore_i;
  logic [4:0]    cmd_start_i;
  logic [5:0]    cmd_len_i;
  logic          done_o, error_o;
  logic          sreg_req_o;
  logic [6:0]    sreg_funct7_o;
  logic [4:0]    sreg_batch_start_o, sreg_batch_len_o;
  logic [DW-1:0] sreg_rs_val_o;
  logic          sreg_ack_i, sreg_error_i;
  logic [DW-1:0] sreg_rd_val_i;
  logic          gpr_rd_req_o;
  logic [4:0]    gpr_rd_base_o;
  logic [DW-1:0] gpr_rd_data_i;
  logic          gpr_wr_o;
  logic [4:0]    gpr_wr_base_o, gpr_wr_len_o;
  logic [DW-1:0] gpr_wr_data_o;

  snapreg_seq #(.BATCH_MAX(BM)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .cmd_valid_i        (cmd_valid_i),
    .cmd_ready_o        (cmd_ready_o),
    .cmd_restore_i      (cmd_restore_i),
    .cmd_start_i        (cmd_start_i),
    .cmd_len_i          (cmd_len_i),
    .done_o             (done_o),
    .error_o            (error_o),
    .sreg_req_o         (sreg_req_o),
    .sreg_funct7_o      (sreg_funct7_o),
    .sreg_batch_start_o (sreg_batch_start_o),
    .sreg_batch_len_o   (sreg_batch_len_o),
    .sreg_rs_val_o      (sreg_rs_val_o),
    .sreg_ack_i         (sreg_ack_i),
    .sreg_error_i       (sreg_error_i),
    .sreg_rd_val_i      (sreg_rd_val_i),
    .gpr_rd_req_o       (gpr_rd_req_o),
    .gpr_rd_base_o      (gpr_rd_base_o),
    .gpr_rd_data_i      (gpr_rd_data_i),
    .gpr_wr_o           (gpr_wr_o),
    .gpr_wr_base_o      (gpr_wr_base_o),
    .gpr_wr_len_o       (gpr_wr_len_o),
    .gpr_wr_data_o      (gpr_wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [6:0]    f7;
    logic [4:0]    st;
    logic [4:0]    ln;
    logic [DW-1:0] d;
  } xact_t;

  typedef struct {
    bit restore;
    int start;
    int len;
    int delay;
    int err_chunk;
    bit exp_err;
    int exp_lat;
  } vec_t;

  vec_t        vecs[12];
  xact_t       sreg_q[$];
  xact_t       gpr_q[$];
  logic [31:0] gpr[32];
  logic [31:0] snap_ref[32];
  logic [31:0] snap_mem[32];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt, rd_req_cnt;
  int rsp_delay, rsp_err_chunk, rsp_chunk, wait_cnt;
  logic       rd_pend;
  logic [4:0] rd_base;
  logic       prev_wait;
  xact_t      prev_x;

  wire logic [OW-1:0] outs = {cmd_ready_o, done_o, error_o, sreg_req_o, sreg_funct7_o,
                              sreg_batch_start_o, sreg_batch_len_o, sreg_rs_val_o,
                              gpr_rd_req_o, gpr_rd_base_o, gpr_wr_o, gpr_wr_base_o,
                              gpr_wr_len_o, gpr_wr_data_o};

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // sel 0: GPR file, 1: expected snapshot contents, 2: responder snapshot contents
  function automatic logic [DW-1:0] mem_lanes(input int sel, input int base, input int len);
    logic [DW-1:0] v;
    int idx;
    v = '0;
    for (int i = 0; i < BM; i++) begin
      if (i < len) begin
        idx = (base + i) % 32;
        v[i*32 +: 32] = (sel == 0) ? gpr[idx] : (sel == 1) ? snap_ref[idx] : snap_mem[idx];
      end
    end
    return v;
  endfunction

  // Responders: GPR read data one cycle after the request, sreg ack after rsp_delay cycles.
  always @(posedge clk_i) begin
    #1;
    if (!rst_ni) begin
      sreg_ack_i   = 1'b0;
      sreg_error_i = 1'b0;
      rd_pend      = 1'b0;
      wait_cnt     = 0;
    end else begin
      if (rd_pend) gpr_rd_data_i = mem_lanes(0, int'(rd_base), BM);
      else for (int i = 0; i < BM; i++) gpr_rd_data_i[i*32 +: 32] = $urandom;
      rd_pend = gpr_rd_req_o;
      rd_base = gpr_rd_base_o;
      if (sreg_ack_i) begin
        sreg_ack_i   = 1'b0;
        sreg_error_i = 1'b0;
        wait_cnt     = 0;
        rsp_chunk++;
        for (int i = 0; i < BM; i++) sreg_rd_val_i[i*32 +: 32] = $urandom;
      end else if (sreg_req_o) begin
        if (wait_cnt >= rsp_delay) begin
          sreg_ack_i   = 1'b1;
          sreg_error_i = (rsp_chunk == rsp_err_chunk);
          if (sreg_funct7_o == 7'h40) sreg_rd_val_i = mem_lanes(2, int'(sreg_batch_start_o), BM);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each completed sreg request and each GPR write.
  always @(negedge clk_i) begin
    xact_t cur_x, exp_x;
    if (!rst_ni) begin
      prev_wait = 1'b0;
    end else begin
      if (done_o) done_cnt++;
      if (gpr_rd_req_o) rd_req_cnt++;
      if (sreg_req_o) begin
        cur_x = {sreg_funct7_o, sreg_batch_start_o, sreg_batch_len_o, sreg_rs_val_o};
        if (prev_wait) chk("sreg_hold", OW'(cur_x), OW'(prev_x));
        prev_wait = !sreg_ack_i;
        prev_x    = cur_x;
        if (sreg_ack_i) begin
          if (sreg_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sreg_unexpected actual=%0h required=none", cur_x);
          end else begin
            exp_x = sreg_q.pop_front();
            chk("sreg_xact", OW'(cur_x), OW'(exp_x));
          end
          if (!sreg_error_i && sreg_funct7_o == 7'h00)
            for (int i = 0; i < int'(sreg_batch_len_o) && i < BM; i++)
              snap_mem[(int'(sreg_batch_start_o) + i) % 32] = sreg_rs_val_o[i*32 +: 32];
        end
      end else begin
        prev_wait = 1'b0;
      end
      if (gpr_wr_o) begin
        cur_x = {7'h00, gpr_wr_base_o, gpr_wr_len_o, gpr_wr_data_o};
        if (gpr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL gpr_wr_unexpected actual=%0h required=none", cur_x);
        end else begin
          exp_x = gpr_q.pop_front();
          chk("gpr_wr_xact", OW'(cur_x), OW'(exp_x));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int b, r, c, k, nrd, c0;
    bit legal, got;
    xact_t x;
    @(negedge clk_i);
    if (v.restore) for (int i = 0; i < 32; i++) gpr[i] = $urandom;
    rsp_delay = v.delay;
    rsp_err_chunk = v.err_chunk;
    rsp_chunk = 0;
    rd_req_cnt = 0;
    done_cnt = 0;
    nrd = 0;
    legal = (v.len != 0) && (v.start + v.len <= 32);
    if (legal) begin
      b = v.start;
      r = v.len;
      k = 0;
      while (r > 0) begin
        c = (r > BM) ? BM : r;
        x.f7 = v.restore ? 7'h40 : 7'h00;
        x.st = b[4:0];
        x.ln = c[4:0];
        x.d  = v.restore ? '0 : mem_lanes(0, b, c);
        sreg_q.push_back(x);
        if (!v.restore) nrd++;
        if (k == v.err_chunk) break;
        if (v.restore) begin
          x.f7 = 7'h00;
          x.d  = mem_lanes(1, b, c);
          gpr_q.push_back(x);
        end else begin
          for (int i = 0; i < c; i++) snap_ref[b + i] = gpr[b + i];
        end
        b += c;
        r -= c;
        k++;
      end
    end
    chk("cmd_ready", OW'(cmd_ready_o), OW'(1));
    cmd_valid_i   = 1'b1;
    cmd_restore_i = v.restore;
    cmd_start_i   = v.start[4:0];
    cmd_len_i     = v.len[5:0];
    c0 = cyc;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    cmd_start_i = 5'($urandom);
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk_i);
      if (done_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=%0d", v.exp_lat);
    end else begin
      chk("done_latency", OW'(cyc - c0), OW'(v.exp_lat));
      chk("done_error", OW'(error_o), OW'(v.exp_err));
    end
    @(negedge clk_i);
    chk("done_pulse", OW'(done_o), OW'(0));
    chk("sreg_left", OW'(sreg_q.size()), OW'(0));
    chk("gpr_wr_left", OW'(gpr_q.size()), OW'(0));
    chk("gpr_rd_count", OW'(rd_req_cnt), OW'(nrd));
    sreg_q.delete();
    gpr_q.delete();
  endtask

  initial begin
    logic [OW-1:0] exp_rst;
    bit got;
    exp_rst = '0;
    exp_rst[OW-1] = 1'b1;
    rst_ni = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_restore_i = 1'b0;
    cmd_start_i = '0;
    cmd_len_i = '0;
    sreg_ack_i = 1'b0;
    sreg_error_i = 1'b0;
    sreg_rd_val_i = '0;
    gpr_rd_data_i = '0;
    rsp_delay = 0;
    rsp_err_chunk = -1;
    rsp_chunk = 0;
    wait_cnt = 0;
    rd_pend = 1'b0;
    rd_base = '0;
    prev_wait = 1'b0;
    done_cnt = 0;
    rd_req_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      gpr[i] = $urandom;
      snap_ref[i] = $urandom;
      snap_mem[i] = snap_ref[i];
    end
    //            restore start len delay err_chunk exp_err exp_lat
    vecs[0]  = '{1'b0,  1, 10, 0, -1, 1'b0, 10};
    vecs[1]  = '{1'b0, 28,  4, 0, -1, 1'b0,  4};
    vecs[2]  = '{1'b1, 28,  4, 0, -1, 1'b0,  3};
    vecs[3]  = '{1'b0, 30,  3, 0, -1, 1'b1,  1};
    vecs[4]  = '{1'b1,  5,  0, 0, -1, 1'b1,  1};
    vecs[5]  = '{1'b0,  0,  6, 2, -1, 1'b0, 11};
    vecs[6]  = '{1'b1,  0,  6, 2, -1, 1'b0,  9};
    vecs[7]  = '{1'b0,  4, 12, 0,  1, 1'b1,  7};
    vecs[8]  = '{1'b1, 20, 12, 0,  1, 1'b1,  4};
    vecs[9]  = '{1'b0,  0, 32, 0, -1, 1'b0, 25};
    vecs[10] = '{1'b1, 31,  1, 0, -1, 1'b0,  3};
    vecs[11] = '{1'b0, 29,  3, 1, -1, 1'b0,  5};

    #13;
    chk("reset_outputs", outs, exp_rst);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Abort a save while it waits for the sreg ack; nothing may complete.
    @(negedge clk_i);
    rsp_delay = 3;
    rsp_err_chunk = -1;
    rsp_chunk = 0;
    done_cnt = 0;
    cmd_valid_i = 1'b1;
    cmd_restore_i = 1'b0;
    cmd_start_i = 5'd0;
    cmd_len_i = 6'd8;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk_i);
      if (sreg_req_o) got = 1'b1;
    end
    chk("rst_reach_swr", OW'(got), OW'(1));
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_outputs", outs, exp_rst);
    @(negedge clk_i);
    chk("rst_hold_outputs", outs, exp_rst);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("rst_no_done", OW'(done_cnt), OW'(0));
    chk("rst_idle_outputs", outs, exp_rst);
    rsp_delay = 0;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
